// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the EX issue controller.
package ibex_pkg;
    typedef enum logic [1:0] {IDLE, MULTI, WB} ex_issue_state_e;
endpackage

// File: rtl/ibex_ex_imd_reg.sv
// ibex_ex_imd_reg: two 34-bit intermediate value registers with per-entry write enable.
module ibex_ex_imd_reg (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       we_i,
    input  logic [1:0][33:0] d_i,
    output logic [1:0][33:0] q_o
);
    logic [1:0][33:0] r_q;
    for (genvar k = 0; k < 2; k++) begin : g_ent
        always_ff @(posedge clk_i) begin
            if (rst_i) r_q[k] <= '0;
            else if (we_i[k]) r_q[k] <= d_i[k];
        end
    end
    assign q_o = r_q;
endmodule

// File: rtl/ibex_ex_issue_ctrl.sv
// ibex_ex_issue_ctrl: EX issue FSM with result buffer and intermediate storage.
// Optional EX-hang watchdog enabled by IBEX_EX_WDOG_EN.
module ibex_ex_issue_ctrl
    import ibex_pkg::*;
#(
    parameter int WdogLimit = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_valid_i,
    input  logic             mult_sel_i,
    input  logic             div_sel_i,
    input  logic             flush_i,
    input  logic             ex_valid_i,
    input  logic [31:0]      result_ex_i,
    input  logic [1:0]       imd_val_we_i,
    input  logic [1:0][33:0] imd_val_d_i,
    input  logic             wb_ready_i,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             alu_instr_first_cycle_o,
    output logic             multdiv_ready_id_o,
    output logic [1:0][33:0] imd_val_q_o,
    output logic             wb_valid_o,
    output logic [31:0]      wb_data_o,
    output logic             instr_done_o,
    output logic             busy_o,
    output logic             wdog_err_o
);
    ex_issue_state_e r_state, w_state_nxt;
    logic [31:0] r_wb_data;
    logic w_go, w_capture, w_first, w_en, w_done, w_wb_valid, w_ready;

    assign w_go = instr_valid_i & ~flush_i;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_first     = 1'b0;
        w_en        = 1'b0;
        w_done      = 1'b0;
        w_wb_valid  = 1'b0;
        w_ready     = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_first = w_go;
                w_en    = w_go;
                if (w_go) begin
                    w_capture   = ex_valid_i;
                    w_state_nxt = ex_valid_i ? WB : MULTI;
                end
            end
            MULTI: begin
                w_en = w_go;
                if (!w_go) w_state_nxt = IDLE;
                else if (ex_valid_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = WB;
                end
            end
            WB: begin
                w_wb_valid = 1'b1;
                w_ready    = wb_ready_i;
                w_done     = wb_ready_i & ~flush_i;
                if (flush_i || wb_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_wb_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) r_wb_data <= result_ex_i;
        end
    end

    // Combinational outputs are held low while reset is asserted.
    assign mult_en_o               = w_en & mult_sel_i & ~rst_i;
    assign div_en_o                = w_en & div_sel_i & ~rst_i;
    assign alu_instr_first_cycle_o = w_first & ~rst_i;
    assign multdiv_ready_id_o      = w_ready & ~rst_i;
    assign wb_valid_o              = w_wb_valid & ~rst_i;
    assign instr_done_o            = w_done & ~rst_i;
    assign busy_o                  = (r_state != IDLE) & ~rst_i;
    assign wb_data_o               = r_wb_data;

    ibex_ex_imd_reg u_imd (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we_i  (imd_val_we_i & {2{~flush_i}}),
        .d_i   (imd_val_d_i),
        .q_o   (imd_val_q_o)
    );

`ifdef IBEX_EX_WDOG_EN
    localparam int CntW = $clog2(WdogLimit + 1);
    logic [CntW-1:0] r_wdog_cnt;
    logic            r_wdog_err;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= (r_state != MULTI) ? '0 :
                          (r_wdog_cnt == CntW'(WdogLimit)) ? r_wdog_cnt : r_wdog_cnt + 1'b1;
            if (r_state == MULTI && r_wdog_cnt == CntW'(WdogLimit - 1)) r_wdog_err <= 1'b1;
        end
    end
    assign wdog_err_o = r_wdog_err;
`else
    assign wdog_err_o = 1'b0 & (WdogLimit > 0);
`endif
endmodule
